// File: rtl/rsp_s1_prep_unpack.sv
// rsp_s1_prep_unpack: buffers prep-RAM words in a FIFO and serialises each into samples
module rsp_s1_prep_unpack #(
    parameter int IN_WIDTH     = 128,
    parameter int SAMPLE_WIDTH = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter bit LSB_FIRST    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_clear,
    input  logic [IN_WIDTH-1:0]           i_data,
    input  logic                          i_data_valid,
    input  logic                          i_data_last,
    output logic [SAMPLE_WIDTH-1:0]       o_sample,
    output logic                          o_sample_valid,
    input  logic                          i_sample_ready,
    output logic                          o_sample_last,
    output logic                          o_frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_almost_full,
    output logic                          o_overflow
);
    localparam int LANES = IN_WIDTH / SAMPLE_WIDTH;
    localparam int LW    = LANES > 1 ? $clog2(LANES) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVW   = AW + 1;

    logic [IN_WIDTH:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [IN_WIDTH-1:0] stage_data;
    logic                stage_last;
    logic [LW-1:0]       lane, sel;
    logic                full, empty, hs, last_lane, pop, push, drop;

    assign full      = o_fifo_level == LVW'(FIFO_DEPTH);
    assign empty     = o_fifo_level == '0;
    assign hs        = o_sample_valid && i_sample_ready;
    assign last_lane = lane == LW'(LANES - 1);
    // refill the stage when it is empty or its final lane is being taken, so words chain without a bubble
    assign pop       = !i_clear && !empty && (!o_sample_valid || (hs && last_lane));
    assign push      = !i_clear && i_data_valid && (!full || pop);
    assign drop      = !i_clear && i_data_valid && full && !pop;
    assign sel       = LSB_FIRST ? lane : LW'(LANES - 1) - lane;

    assign o_sample      = stage_data[sel*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign o_sample_last = o_sample_valid && stage_last && last_lane;
    assign o_almost_full = o_fifo_level >= LVW'(FIFO_DEPTH - 2);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {i_data_last, i_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_fifo_level   <= '0;
            o_overflow     <= 1'b0;
            o_frame_done   <= 1'b0;
            o_sample_valid <= 1'b0;
            lane           <= '0;
            stage_data     <= '0;
            stage_last     <= 1'b0;
        end else if (i_clear) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_fifo_level   <= '0;
            o_overflow     <= 1'b0;
            o_frame_done   <= 1'b0;
            o_sample_valid <= 1'b0;
            lane           <= '0;
        end else begin
            wr_ptr       <= wr_ptr + AW'(push);
            rd_ptr       <= rd_ptr + AW'(pop);
            o_fifo_level <= o_fifo_level + LVW'(push) - LVW'(pop);
            o_overflow   <= o_overflow || drop;
            o_frame_done <= hs && o_sample_last;
            if (pop) begin
                {stage_last, stage_data} <= mem[rd_ptr];
                lane                     <= '0;
                o_sample_valid           <= 1'b1;
            end else if (hs) begin
                lane           <= last_lane ? '0 : lane + 1'b1;
                o_sample_valid <= !last_lane;
            end
        end
    end
endmodule
